parity_unit: RTL

- Parametrised parity generator/checker for the UART datapath; replaces the fixed 8-bit even/odd generator.
- Generator path: captures a DATA_WIDTH-bit word on a valid/busy handshake and produces a registered parity bit plus a one-cycle valid strobe.
- Checker path: accumulates parity serially over received data bits, then compares it with the received parity bit and flags errors.
- Parity modes: even, odd, mark, space, or disabled.

---
 rtl/parity_pkg.sv | 15 +
 rtl/parity_sel.sv | 24 ++
 rtl/parity_unit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// Shared parity mode codes and checker state encoding for the UART parity unit.
package parity_pkg;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  typedef enum logic [1:0] {
    CHK_IDLE = 2'd0,
    CHK_ACC  = 2'd1,
    CHK_CMP  = 2'd2
  } chk_state_t;

endpackage

// File: rtl/parity_sel.sv
// Combinational parity mode decoder: maps a data XOR, mode and enable to the parity bit.
// Zero latency; no flow control.
module parity_sel
  import parity_pkg::*;
(
  input  logic       data_xor,
  input  logic [1:0] mode,
  input  logic       en,
  output logic       par
);

  always_comb begin
    par = 1'b0;
    if (en) begin
      case (mode)
        PAR_EVEN: par = data_xor;
        PAR_ODD:  par = ~data_xor;
        PAR_MARK: par = 1'b1;
        default:  par = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/parity_unit.sv
// Parity generator (capture on Data_Valid & ~busy, par_bit/par_valid two edges later)
// and serial parity checker (chk_done one edge after the final strobe); busy blocks capture.
module parity_unit
  import parity_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  busy,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_TYP,
  input  logic                  S_START,
  input  logic                  S_EN,
  input  logic                  S_BIT,
  output logic                  par_bit,
  output logic                  par_valid,
  output logic                  chk_done,
  output logic                  par_err,
  output logic                  chk_busy
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH);

  // ---------------- generator ----------------
  logic [DATA_WIDTH-1:0] cap_data;
  logic [1:0]            cap_typ;
  logic                  cap_en;
  logic                  cap_vld;
  logic                  gen_par;
  logic                  capture;

  assign capture = Data_Valid & ~busy;

  parity_sel u_gen_sel (
    .data_xor (^cap_data),
    .mode     (cap_typ),
    .en       (cap_en),
    .par      (gen_par)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cap_data  <= '0;
      cap_typ   <= 2'b00;
      cap_en    <= 1'b0;
      cap_vld   <= 1'b0;
      par_bit   <= 1'b0;
      par_valid <= 1'b0;
    end else begin
      cap_vld <= capture;
      if (capture) begin
        cap_data <= P_DATA;
        cap_typ  <= PAR_TYP;
        cap_en   <= PAR_EN;
      end
      // par_bit follows the captured word even when disabled; only the strobe is gated.
      if (cap_vld) begin
        par_bit   <= gen_par;
        par_valid <= cap_en;
      end else begin
        par_valid <= 1'b0;
      end
    end
  end

  // ---------------- checker ----------------
  chk_state_t       state_q, state_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       snap_typ_q, snap_typ_d;
  logic             snap_en_q, snap_en_d;
  logic             done_d;
  logic             err_d;
  logic             chk_exp;

  parity_sel u_chk_sel (
    .data_xor (acc_q),
    .mode     (snap_typ_q),
    .en       (snap_en_q),
    .par      (chk_exp)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    snap_typ_d = snap_typ_q;
    snap_en_d  = snap_en_q;
    done_d     = 1'b0;
    err_d      = par_err;
    cnt_inc    = cnt_q + CNT_W'(1);

    // A start discards any coincident bit strobe.
    if (S_START) begin
      state_d    = CHK_ACC;
      acc_d      = 1'b0;
      cnt_d      = '0;
      err_d      = 1'b0;
      snap_typ_d = PAR_TYP;
      snap_en_d  = PAR_EN;
    end else if (S_EN) begin
      case (state_q)
        CHK_ACC: begin
          acc_d = acc_q ^ S_BIT;
          cnt_d = cnt_inc;
          if (cnt_inc == LAST_BIT) begin
            if (snap_en_q) begin
              state_d = CHK_CMP;
            end else begin
              done_d  = 1'b1;
              err_d   = 1'b0;
              state_d = CHK_IDLE;
            end
          end
        end
        CHK_CMP: begin
          err_d   = (S_BIT != chk_exp);
          done_d  = 1'b1;
          state_d = CHK_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= CHK_IDLE;
      acc_q      <= 1'b0;
      cnt_q      <= '0;
      snap_typ_q <= 2'b00;
      snap_en_q  <= 1'b0;
      chk_done   <= 1'b0;
      par_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      snap_typ_q <= snap_typ_d;
      snap_en_q  <= snap_en_d;
      chk_done   <= done_d;
      par_err    <= err_d;
    end
  end

  assign chk_busy = (state_q != CHK_IDLE);

endmodule
